// File: rtl/game_pkg.sv
// Shared tic-tac-toe board definitions: FSM states, winner codes,
// pixel bounds of the 3x3 grid cells and the 8 winning line masks.
package game_pkg;

    typedef enum logic [1:0] {
        TURN_X = 2'd0,
        TURN_O = 2'd1,
        CHECK  = 2'd2,
        OVER   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    // Strict (exclusive) bounds; pixels on the bounds are grid lines.
    localparam int unsigned COL0_LO = 0;
    localparam int unsigned COL0_HI = 78;
    localparam int unsigned COL1_LO = 80;
    localparam int unsigned COL1_HI = 158;
    localparam int unsigned COL2_LO = 160;
    localparam int unsigned COL2_HI = 238;
    localparam int unsigned ROW2_LO = 41;
    localparam int unsigned ROW2_HI = 119;
    localparam int unsigned ROW1_LO = 121;
    localparam int unsigned ROW1_HI = 199;
    localparam int unsigned ROW0_LO = 201;
    localparam int unsigned ROW0_HI = 279;

    localparam logic [3:0] FULL_BOARD = 4'd9;

    // Cell index = col*3 + row. Bits 0-2 columns, 3-5 rows, 6-7 diagonals.
    localparam logic [7:0][8:0] LINE_MASK = {
        9'b001_010_100,
        9'b100_010_001,
        9'b100_100_100,
        9'b010_010_010,
        9'b001_001_001,
        9'b111_000_000,
        9'b000_111_000,
        9'b000_000_111
    };

    function automatic logic [7:0] line_hits(input logic [8:0] b);
        logic [7:0] h;
        for (int i = 0; i < 8; i++) begin
            h[i] = (b & LINE_MASK[i]) == LINE_MASK[i];
        end
        return h;
    endfunction

    // One move can close two lines at once; report the lowest one.
    function automatic logic [7:0] lowest_one(input logic [7:0] h);
        return h & (~h + 8'd1);
    endfunction

endpackage

// File: rtl/board_cell_decoder.sv
// Combinational mouse-coordinate to board-cell decoder.
// Ports: x, y in; cell_idx (col*3+row) and cell_valid out.
module board_cell_decoder
    import game_pkg::*;
#(
    parameter int SCREEN_WIDTH       = 240,
    parameter int SCREEN_HEIGHT      = 320,
    parameter int BITS_SCREEN_WIDTH  = 8,
    parameter int BITS_SCREEN_HEIGHT = 9
) (
    input  logic [BITS_SCREEN_WIDTH-1:0]  x,
    input  logic [BITS_SCREEN_HEIGHT-1:0] y,
    output logic [3:0]                    cell_idx,
    output logic                          cell_valid
);

    logic [31:0] xe;
    logic [31:0] ye;
    logic [1:0]  col;
    logic [1:0]  row;
    logic        col_ok;
    logic        row_ok;
    logic        on_screen;

    always_comb begin
        xe     = 32'(x);
        ye     = 32'(y);
        col    = 2'd0;
        row    = 2'd0;
        col_ok = 1'b1;
        row_ok = 1'b1;

        if (xe > COL0_LO && xe < COL0_HI) begin
            col = 2'd0;
        end else if (xe > COL1_LO && xe < COL1_HI) begin
            col = 2'd1;
        end else if (xe > COL2_LO && xe < COL2_HI) begin
            col = 2'd2;
        end else begin
            col_ok = 1'b0;
        end

        // Row 0 is the bottom band of the screen.
        if (ye > ROW0_LO && ye < ROW0_HI) begin
            row = 2'd0;
        end else if (ye > ROW1_LO && ye < ROW1_HI) begin
            row = 2'd1;
        end else if (ye > ROW2_LO && ye < ROW2_HI) begin
            row = 2'd2;
        end else begin
            row_ok = 1'b0;
        end

        on_screen  = xe < 32'(SCREEN_WIDTH) && ye < 32'(SCREEN_HEIGHT);
        cell_valid = col_ok && row_ok && on_screen;
        cell_idx   = cell_valid ? (4'(col) * 4'd3 + 4'(row)) : 4'd0;
    end

endmodule

// File: rtl/game_board_controller.sv
// Tic-tac-toe board controller: accepts clicks, tracks X/O marks,
// alternates turns and detects win or draw. All outputs registered.
module game_board_controller
    import game_pkg::*;
#(
    parameter int SCREEN_WIDTH       = 240,
    parameter int SCREEN_HEIGHT      = 320,
    parameter int BITS_SCREEN_WIDTH  = 8,
    parameter int BITS_SCREEN_HEIGHT = 9
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          click,
    input  logic [BITS_SCREEN_WIDTH-1:0]  xMouse,
    input  logic [BITS_SCREEN_HEIGHT-1:0] yMouse,
    input  logic                          new_game,
    output logic [8:0]                    x_status,
    output logic [8:0]                    o_status,
    output logic                          turn_o,
    output logic [1:0]                    winner,
    output logic                          game_over,
    output logic [7:0]                    win_line
);

    state_e     state_q,     state_d;
    logic [8:0] x_q,         x_d;
    logic [8:0] o_q,         o_d;
    logic       turn_o_q,    turn_o_d;
    winner_e    winner_q,    winner_d;
    logic       game_over_q, game_over_d;
    logic [7:0] win_line_q,  win_line_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       mover_q,     mover_d;

    logic [3:0] cell_idx;
    logic       cell_valid;
    logic [8:0] occupied;
    logic [7:0] hits;

    board_cell_decoder #(
        .SCREEN_WIDTH      (SCREEN_WIDTH),
        .SCREEN_HEIGHT     (SCREEN_HEIGHT),
        .BITS_SCREEN_WIDTH (BITS_SCREEN_WIDTH),
        .BITS_SCREEN_HEIGHT(BITS_SCREEN_HEIGHT)
    ) u_dec (
        .x         (xMouse),
        .y         (yMouse),
        .cell_idx  (cell_idx),
        .cell_valid(cell_valid)
    );

    assign occupied = x_q | o_q;
    assign hits     = line_hits(mover_q ? o_q : x_q);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        o_d         = o_q;
        turn_o_d    = turn_o_q;
        winner_d    = winner_q;
        game_over_d = game_over_q;
        win_line_d  = win_line_q;
        cnt_d       = cnt_q;
        mover_d     = mover_q;

        if (new_game) begin
            state_d     = TURN_X;
            x_d         = '0;
            o_d         = '0;
            turn_o_d    = 1'b0;
            winner_d    = WIN_NONE;
            game_over_d = 1'b0;
            win_line_d  = '0;
            cnt_d       = '0;
            mover_d     = 1'b0;
        end else begin
            unique case (state_q)
                TURN_X, TURN_O: begin
                    if (click && cell_valid && !occupied[cell_idx]) begin
                        if (state_q == TURN_O) begin
                            o_d[cell_idx] = 1'b1;
                        end else begin
                            x_d[cell_idx] = 1'b1;
                        end
                        mover_d = (state_q == TURN_O);
                        cnt_d   = cnt_q + 4'd1;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (|hits) begin
                        winner_d    = mover_q ? WIN_O : WIN_X;
                        win_line_d  = lowest_one(hits);
                        game_over_d = 1'b1;
                        state_d     = OVER;
                    end else if (cnt_q == FULL_BOARD) begin
                        winner_d    = WIN_DRAW;
                        win_line_d  = '0;
                        game_over_d = 1'b1;
                        state_d     = OVER;
                    end else begin
                        turn_o_d = ~mover_q;
                        state_d  = mover_q ? TURN_X : TURN_O;
                    end
                end
                OVER: begin
                end
                default: begin
                    state_d = TURN_X;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= TURN_X;
            x_q         <= '0;
            o_q         <= '0;
            turn_o_q    <= 1'b0;
            winner_q    <= WIN_NONE;
            game_over_q <= 1'b0;
            win_line_q  <= '0;
            cnt_q       <= '0;
            mover_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            o_q         <= o_d;
            turn_o_q    <= turn_o_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            win_line_q  <= win_line_d;
            cnt_q       <= cnt_d;
            mover_q     <= mover_d;
        end
    end

    assign x_status  = x_q;
    assign o_status  = o_q;
    assign turn_o    = turn_o_q;
    assign winner    = winner_q;
    assign game_over = game_over_q;
    assign win_line  = win_line_q;

endmodule

// File: tb/tb_game_board_controller.sv
// Directed self-checking bench for game_board_controller.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_game_board_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       click = 1'b0;
    logic [7:0] xMouse = '0;
    logic [8:0] yMouse = '0;
    logic       new_game = 1'b0;
    logic [8:0] x_status;
    logic [8:0] o_status;
    logic       turn_o;
    logic [1:0] winner;
    logic       game_over;
    logic [7:0] win_line;

    int n_tests = 0;
    int n_fail  = 0;

    game_board_controller dut (
        .clock    (clock),
        .reset    (reset),
        .click    (click),
        .xMouse   (xMouse),
        .yMouse   (yMouse),
        .new_game (new_game),
        .x_status (x_status),
        .o_status (o_status),
        .turn_o   (turn_o),
        .winner   (winner),
        .game_over(game_over),
        .win_line (win_line)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_cell(input int c);
        xMouse = 8'(40 + 80 * (c / 3));
        yMouse = 9'(240 - 80 * (c % 3));
    endtask

    // Click held for one rising edge; returns just after it.
    task automatic place(input int c);
        set_cell(c);
        click = 1'b1;
        step();
        click = 1'b0;
    endtask

    task automatic move(input int c);
        place(c);
        step();
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"}, int'(x_status), 0);
        chk({tag, "_o"}, int'(o_status), 0);
        chk({tag, "_turn"}, int'(turn_o), 0);
        chk({tag, "_win"}, int'(winner), 0);
        chk({tag, "_over"}, int'(game_over), 0);
        chk({tag, "_line"}, int'(win_line), 0);
    endtask

    initial begin
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_all_zero("rst");

        // First move at (40,240): cell 0.
        place(0);
        chk("mv1_x", int'(x_status), 'h001);
        chk("mv1_turn_early", int'(turn_o), 0);
        step();
        chk("mv1_turn", int'(turn_o), 1);
        chk("mv1_over", int'(game_over), 0);

        // Click on the vertical grid line.
        xMouse = 8'd79;
        yMouse = 9'd240;
        click = 1'b1;
        step();
        click = 1'b0;
        step();
        chk("grid_x", int'(x_status), 'h001);
        chk("grid_o", int'(o_status), 0);
        chk("grid_turn", int'(turn_o), 1);

        // O clicks on already-occupied cell 0.
        move(0);
        chk("occ_x", int'(x_status), 'h001);
        chk("occ_o", int'(o_status), 0);
        chk("occ_turn", int'(turn_o), 1);

        // Column-0 win for X.
        pulse_new_game();
        chk_all_zero("ng1");
        move(0);
        move(3);
        move(1);
        move(4);
        place(2);
        chk("win_x_early", int'(x_status), 'h007);
        chk("win_over_early", int'(game_over), 0);
        step();
        chk("win_who", int'(winner), 1);
        chk("win_line", int'(win_line), 'h01);
        chk("win_over", int'(game_over), 1);
        chk("win_o", int'(o_status), 'h018);
        move(8);
        step();
        chk("over_x", int'(x_status), 'h007);
        chk("over_o", int'(o_status), 'h018);
        chk("over_who", int'(winner), 1);
        chk("over_flag", int'(game_over), 1);

        // Full board with no line.
        pulse_new_game();
        move(0);
        move(2);
        move(1);
        move(3);
        move(5);
        move(4);
        move(6);
        move(7);
        chk("draw8_over", int'(game_over), 0);
        chk("draw8_who", int'(winner), 0);
        move(8);
        chk("draw_who", int'(winner), 3);
        chk("draw_over", int'(game_over), 1);
        chk("draw_line", int'(win_line), 0);
        chk("draw_x", int'(x_status), 'h163);
        chk("draw_o", int'(o_status), 'h09C);

        // new_game wins over a simultaneous click.
        pulse_new_game();
        move(0);
        set_cell(4);
        click = 1'b1;
        new_game = 1'b1;
        step();
        click = 1'b0;
        new_game = 1'b0;
        chk_all_zero("ngclk");
        step();
        chk("ngclk_o2", int'(o_status), 0);
        chk("ngclk_x2", int'(x_status), 0);
        move(4);
        chk("ngclk_after_x", int'(x_status), 'h010);
        chk("ngclk_after_turn", int'(turn_o), 1);

        // Reset while the controller sits in CHECK.
        pulse_new_game();
        place(0);
        chk("rchk_pre_x", int'(x_status), 'h001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("rchk");
        step();
        chk("rchk_turn_hold", int'(turn_o), 0);
        move(2);
        chk("rchk_next_x", int'(x_status), 'h004);
        chk("rchk_next_o", int'(o_status), 0);
        chk("rchk_next_turn", int'(turn_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
